mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, sitting between the E/M pipeline register and the writeback stage. Issues loads and stores to the data bus with a req/ack handshake. Generates byte enables and alignment exceptions, and stalls the pipeline while a bus access is outstanding. Registers everything the writeback stage consumes: instruction, mux selects, PC+8, ALU result, raw memory word and CP0 read data.

---
 rtl/mips_defs.sv | 39 +++
 rtl/store_align.sv | 42 ++++
 rtl/mem_stage.sv | 202 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the memory-access stage: access encodings, exception
// codes, bus FSM states and the writeback register layout.
package mips_defs;

  localparam logic [1:0] ST_SW = 2'd0;
  localparam logic [1:0] ST_SH = 2'd1;
  localparam logic [1:0] ST_SB = 2'd2;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LBU = 3'd1;
  localparam logic [2:0] LT_LB  = 3'd2;
  localparam logic [2:0] LT_LHU = 3'd3;
  localparam logic [2:0] LT_LH  = 3'd4;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'd0,
    MS_WAIT  = 2'd1,
    MS_DRAIN = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] ao;
    logic [31:0] dm_data;
    logic [31:0] cp0_data;
    logic [1:0]  data2reg;
    logic [1:0]  reg_dst;
    logic [2:0]  load_type;
    logic        valid;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '0;

endpackage

// File: rtl/store_align.sv
// Byte-enable, store-lane replication and alignment check for one access,
// derived from the access type and the low address bits.
module store_align
  import mips_defs::*;
(
  input  logic        is_store,
  input  logic [1:0]  store_type,
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign
);

  always_comb begin
    be       = 4'b1111;
    wdata    = wd;
    misalign = 1'b0;
    if (is_store) begin
      case (store_type)
        ST_SH: begin
          be       = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata    = {2{wd[15:0]}};
          misalign = addr_lo[0];
        end
        ST_SB: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{wd[7:0]}};
        end
        default: misalign = |addr_lo;
      endcase
    end else begin
      case (load_type)
        LT_LW:         misalign = |addr_lo;
        LT_LHU, LT_LH: misalign = addr_lo[0];
        default:       misalign = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: req/ack data-bus master with alignment and bus-error
// exceptions, pipeline stall while an access is outstanding, and the M/W register.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// MS_IDLE  | bus driven straight from M; an unacked request moves to MS_WAIT
// MS_WAIT  | access outstanding, bus driven from hold registers
// MS_DRAIN | M was flushed mid-access; finish the handshake, discard rdata
module mem_stage
  import mips_defs::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_M,
  input  logic [31:0] PC8_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] WD_M,
  input  logic [31:0] cp0Data_M,
  input  logic        valid_M,
  input  logic        memRead_M,
  input  logic        memWrite_M,
  input  logic [1:0]  storeType_M,
  input  logic [2:0]  loadType_M,
  input  logic [1:0]  Data2Reg_M,
  input  logic [1:0]  RegDst_M,
  input  logic        flush_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_M,
  output logic        exc_M,
  output logic [4:0]  excCode_M,
  output logic [31:0] instr_W,
  output logic [31:0] PC8_W,
  output logic [31:0] AO_W,
  output logic [31:0] DMData_W,
  output logic [31:0] cp0Data_W,
  output logic [1:0]  Data2Reg_W,
  output logic [1:0]  RegDst_W,
  output logic [2:0]  loadType_W,
  output logic        valid_W
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic          err_q, err_d;
  logic [31:0]   hold_addr_q, hold_wdata_q;
  logic [3:0]    hold_be_q;
  logic          hold_we_q;
  w_reg_t        w_q, w_d;

  logic          mem_op, misalign, req_idle, timeout, load_acked;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;

  assign mem_op = valid_M & (memRead_M | memWrite_M) & ~flush_M;

  store_align u_store_align (
    .is_store   (memWrite_M),
    .store_type (storeType_M),
    .load_type  (loadType_M),
    .addr_lo    (AO_M[1:0]),
    .wd         (WD_M),
    .be         (be_calc),
    .wdata      (wdata_calc),
    .misalign   (misalign)
  );

  // The cycle after a bus error reports DBE and must not reissue the same access.
  assign req_idle = mem_op & ~misalign & ~err_q;
  assign cnt_inc  = cnt_q + CW'(1);
  assign timeout  = (cnt_inc == CW'(TIMEOUT)) & ~bus_ack;

  always_comb begin
    state_d    = state_q;
    err_d      = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_be     = 4'b0000;
    bus_addr   = {AO_M[31:2], 2'b00};
    bus_wdata  = wdata_calc;
    stall_M    = 1'b0;
    exc_M      = 1'b0;
    excCode_M  = 5'd0;
    load_acked = 1'b0;
    case (state_q)
      MS_IDLE: begin
        bus_req    = req_idle;
        bus_we     = req_idle & memWrite_M;
        bus_be     = req_idle ? be_calc : 4'b0000;
        stall_M    = req_idle & ~bus_ack;
        load_acked = req_idle & bus_ack & ~memWrite_M;
        if (err_q) begin
          exc_M     = 1'b1;
          excCode_M = EXC_DBE;
        end else if (mem_op & misalign) begin
          exc_M     = 1'b1;
          excCode_M = memWrite_M ? EXC_ADES : EXC_ADEL;
        end
        if (req_idle & ~bus_ack) state_d = MS_WAIT;
      end
      MS_WAIT: begin
        bus_req    = 1'b1;
        bus_we     = hold_we_q;
        bus_be     = hold_be_q;
        bus_addr   = hold_addr_q;
        bus_wdata  = hold_wdata_q;
        // The ack cycle itself is not stalled so W can take rdata on this edge.
        stall_M    = ~bus_ack;
        load_acked = bus_ack & ~hold_we_q;
        if (bus_ack) begin
          state_d = MS_IDLE;
        end else if (timeout) begin
          state_d = MS_IDLE;
          err_d   = ~flush_M;
        end else if (flush_M) begin
          state_d = MS_DRAIN;
        end
      end
      MS_DRAIN: begin
        bus_req   = 1'b1;
        bus_we    = hold_we_q;
        bus_be    = hold_be_q;
        bus_addr  = hold_addr_q;
        bus_wdata = hold_wdata_q;
        stall_M   = 1'b1;
        if (bus_ack | timeout) state_d = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
    // Reset must silence the bus at once, even while M still presents an access.
    if (reset) begin
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_be    = 4'b0000;
      stall_M   = 1'b0;
      exc_M     = 1'b0;
      excCode_M = 5'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= MS_IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      hold_addr_q  <= 32'h0;
      hold_wdata_q <= 32'h0;
      hold_be_q    <= 4'b0000;
      hold_we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= (state_q == MS_IDLE || state_d == MS_IDLE) ? '0 : cnt_inc;
      if (state_q == MS_IDLE && req_idle && !bus_ack) begin
        hold_addr_q  <= {AO_M[31:2], 2'b00};
        hold_wdata_q <= wdata_calc;
        hold_be_q    <= be_calc;
        hold_we_q    <= memWrite_M;
      end
    end
  end

  always_comb begin
    w_d = W_BUBBLE;
    if (!(stall_M || flush_M || exc_M)) begin
      w_d.instr     = instr_M;
      w_d.pc8       = PC8_M;
      w_d.ao        = AO_M;
      w_d.dm_data   = load_acked ? bus_rdata : 32'h0;
      w_d.cp0_data  = cp0Data_M;
      w_d.data2reg  = Data2Reg_M;
      w_d.reg_dst   = RegDst_M;
      w_d.load_type = loadType_M;
      w_d.valid     = valid_M;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) w_q <= W_BUBBLE;
    else       w_q <= w_d;
  end

  assign instr_W    = w_q.instr;
  assign PC8_W      = w_q.pc8;
  assign AO_W       = w_q.ao;
  assign DMData_W   = w_q.dm_data;
  assign cp0Data_W  = w_q.cp0_data;
  assign Data2Reg_W = w_q.data2reg;
  assign RegDst_W   = w_q.reg_dst;
  assign loadType_W = w_q.load_type;
  assign valid_W    = w_q.valid;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT=4: zero-wait and waited accesses,
// alignment exceptions, flush drain, bus timeout and reset mid-access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_M, PC8_M, AO_M, WD_M, cp0Data_M;
  logic        valid_M, memRead_M, memWrite_M, flush_M;
  logic [1:0]  storeType_M, Data2Reg_M, RegDst_M;
  logic [2:0]  loadType_M;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        stall_M, exc_M;
  logic [4:0]  excCode_M;
  logic [31:0] instr_W, PC8_W, AO_W, DMData_W, cp0Data_W;
  logic [1:0]  Data2Reg_W, RegDst_W;
  logic [2:0]  loadType_W;
  logic        valid_W;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .instr_M(instr_M), .PC8_M(PC8_M), .AO_M(AO_M), .WD_M(WD_M), .cp0Data_M(cp0Data_M),
    .valid_M(valid_M), .memRead_M(memRead_M), .memWrite_M(memWrite_M),
    .storeType_M(storeType_M), .loadType_M(loadType_M),
    .Data2Reg_M(Data2Reg_M), .RegDst_M(RegDst_M), .flush_M(flush_M),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_M(stall_M), .exc_M(exc_M), .excCode_M(excCode_M),
    .instr_W(instr_W), .PC8_W(PC8_W), .AO_W(AO_W), .DMData_W(DMData_W),
    .cp0Data_W(cp0Data_W), .Data2Reg_W(Data2Reg_W), .RegDst_W(RegDst_W),
    .loadType_W(loadType_W), .valid_W(valid_W)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic m_idle();
    instr_M = 32'h0; PC8_M = 32'h0; AO_M = 32'h0; WD_M = 32'h0; cp0Data_M = 32'h0;
    valid_M = 1'b0; memRead_M = 1'b0; memWrite_M = 1'b0; flush_M = 1'b0;
    storeType_M = 2'd0; loadType_M = 3'd0; Data2Reg_M = 2'd0; RegDst_M = 2'd0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
  endtask

  task automatic m_mem(input logic [31:0] ins, input logic [31:0] ao, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic [1:0] st, input logic [2:0] lt);
    m_idle();
    instr_M = ins; AO_M = ao; WD_M = wd; PC8_M = ao + 32'h1000;
    valid_M = 1'b1; memRead_M = rd; memWrite_M = wr; storeType_M = st; loadType_M = lt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   32'(bus_req), 0);
    chk("rst_be",    32'(bus_be), 0);
    chk("rst_stall", 32'(stall_M), 0);
    chk("rst_exc",   32'(exc_M), 0);
    chk("rst_vw",    32'(valid_W), 0);
    chk("rst_instr", instr_W, 0);
    reset = 1'b0;

    // sw, zero-wait
    m_mem(32'hAC01_0000, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 2'd0, 3'd0);
    bus_ack = 1'b1;
    #1;
    chk("sw_req",   32'(bus_req), 1);
    chk("sw_we",    32'(bus_we), 1);
    chk("sw_be",    32'(bus_be), 32'hF);
    chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
    chk("sw_addr",  bus_addr, 32'h100);
    chk("sw_stall", 32'(stall_M), 0);
    chk("sw_exc",   32'(exc_M), 0);
    tick();
    chk("sw_vw",    32'(valid_W), 1);
    chk("sw_aow",   AO_W, 32'h100);
    chk("sw_insw",  instr_W, 32'hAC01_0000);
    chk("sw_dmw",   DMData_W, 0);

    // non-memory instruction passes straight through
    m_idle();
    valid_M = 1'b1; instr_M = 32'h4000_0000; PC8_M = 32'h0000_3008; AO_M = 32'h77;
    cp0Data_M = 32'hC0C0_0001; Data2Reg_M = 2'd3; RegDst_M = 2'd2; loadType_M = 3'd4;
    #1;
    chk("alu_req", 32'(bus_req), 0);
    tick();
    chk("alu_pc8",  PC8_W, 32'h0000_3008);
    chk("alu_cp0",  cp0Data_W, 32'hC0C0_0001);
    chk("alu_d2r",  32'(Data2Reg_W), 3);
    chk("alu_rdst", 32'(RegDst_W), 2);
    chk("alu_lt",   32'(loadType_W), 4);
    chk("alu_vw",   32'(valid_W), 1);

    // sb at byte 3 and sh at upper half, zero-wait
    m_mem(32'hA000_0001, 32'h203, 32'h0000_00A5, 1'b0, 1'b1, 2'd2, 3'd0);
    bus_ack = 1'b1;
    #1;
    chk("sb_be",    32'(bus_be), 32'h8);
    chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
    chk("sb_addr",  bus_addr, 32'h200);
    tick();
    m_mem(32'hA400_0002, 32'h102, 32'h1234_BEEF, 1'b0, 1'b1, 2'd1, 3'd0);
    bus_ack = 1'b1;
    #1;
    chk("sh_be",    32'(bus_be), 32'hC);
    chk("sh_wdata", bus_wdata, 32'hBEEFBEEF);
    tick();

    // lb with three wait cycles
    m_mem(32'h8000_0003, 32'h203, 32'h0, 1'b1, 1'b0, 2'd0, 3'd2);
    #1;
    chk("lb_req",  32'(bus_req), 1);
    chk("lb_we",   32'(bus_we), 0);
    chk("lb_be",   32'(bus_be), 32'hF);
    chk("lb_addr", bus_addr, 32'h200);
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall", 32'(stall_M), 1);
      tick();
      chk("lb_bubble", 32'(valid_W), 0);
    end
    bus_ack = 1'b1; bus_rdata = 32'h11223344;
    #1;
    chk("lb_ack_stall", 32'(stall_M), 0);
    chk("lb_ack_addr",  bus_addr, 32'h200);
    tick();
    m_idle();
    chk("lb_dmw", DMData_W, 32'h11223344);
    chk("lb_ltw", 32'(loadType_W), 2);
    chk("lb_vw",  32'(valid_W), 1);
    chk("lb_aow", AO_W, 32'h203);

    // misaligned sh -> AdES, misaligned lw -> AdEL
    m_mem(32'hA400_0004, 32'h101, 32'h5555, 1'b0, 1'b1, 2'd1, 3'd0);
    #1;
    chk("ades_exc",   32'(exc_M), 1);
    chk("ades_code",  32'(excCode_M), 5);
    chk("ades_req",   32'(bus_req), 0);
    chk("ades_stall", 32'(stall_M), 0);
    tick();
    chk("ades_vw",    32'(valid_W), 0);
    chk("ades_insw",  instr_W, 0);
    m_mem(32'h8C00_0005, 32'h102, 32'h0, 1'b1, 1'b0, 2'd0, 3'd0);
    #1;
    chk("adel_exc",  32'(exc_M), 1);
    chk("adel_code", 32'(excCode_M), 4);
    chk("adel_req",  32'(bus_req), 0);
    tick();

    // lw flushed in the second wait cycle, drained two cycles later
    m_mem(32'h8C00_0006, 32'h300, 32'h0, 1'b1, 1'b0, 2'd0, 3'd0);
    #1;
    chk("fl_stall0", 32'(stall_M), 1);
    tick();
    tick();
    flush_M = 1'b1;
    #1;
    chk("fl_exc",    32'(exc_M), 0);
    chk("fl_stall2", 32'(stall_M), 1);
    tick();
    m_idle();
    #1;
    chk("fl_d1_req",  32'(bus_req), 1);
    chk("fl_d1_addr", bus_addr, 32'h300);
    chk("fl_d1_vw",   32'(valid_W), 0);
    chk("fl_d1_stall", 32'(stall_M), 1);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    #1;
    chk("fl_d2_req", 32'(bus_req), 1);
    chk("fl_d2_exc", 32'(exc_M), 0);
    tick();
    bus_ack = 1'b0;
    #1;
    chk("fl_end_vw",    32'(valid_W), 0);
    chk("fl_end_dmw",   DMData_W, 0);
    chk("fl_end_req",   32'(bus_req), 0);
    chk("fl_end_stall", 32'(stall_M), 0);

    // lw that is never acked -> bus error after four wait cycles
    m_mem(32'h8C00_0007, 32'h400, 32'h0, 1'b1, 1'b0, 2'd0, 3'd0);
    #1;
    chk("to_req0", 32'(bus_req), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_wait_req", 32'(bus_req), 1);
      chk("to_wait_exc", 32'(exc_M), 0);
    end
    tick();
    chk("to_req",   32'(bus_req), 0);
    chk("to_exc",   32'(exc_M), 1);
    chk("to_code",  32'(excCode_M), 7);
    chk("to_stall", 32'(stall_M), 0);
    tick();
    m_idle();
    #1;
    chk("to_vw",     32'(valid_W), 0);
    chk("to_exc_clr", 32'(exc_M), 0);

    // ack in the fourth wait cycle is still a success
    m_mem(32'h8C00_0008, 32'h500, 32'h0, 1'b1, 1'b0, 2'd0, 3'd0);
    for (int i = 0; i < 4; i++) tick();
    bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
    #1;
    chk("bd_exc",   32'(exc_M), 0);
    chk("bd_stall", 32'(stall_M), 0);
    tick();
    m_idle();
    #1;
    chk("bd_vw",  32'(valid_W), 1);
    chk("bd_dmw", DMData_W, 32'h55AA55AA);
    chk("bd_exc_after", 32'(exc_M), 0);

    // reset asserted while waiting
    m_mem(32'h8C00_0009, 32'h600, 32'h0, 1'b1, 1'b0, 2'd0, 3'd0);
    tick();
    tick();
    chk("rw_req_pre", 32'(bus_req), 1);
    reset = 1'b1;
    #1;
    chk("rw_req",   32'(bus_req), 0);
    chk("rw_stall", 32'(stall_M), 0);
    chk("rw_be",    32'(bus_be), 0);
    chk("rw_vw",    32'(valid_W), 0);
    chk("rw_insw",  instr_W, 0);
    chk("rw_aow",   AO_W, 0);
    tick();
    m_idle();
    reset = 1'b0;
    tick();
    chk("rw_idle_req", 32'(bus_req), 0);
    chk("rw_idle_stall", 32'(stall_M), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
